adc_sample_sequencer: RTL and testbench

- Sits downstream of the PWM hold detector in the FOC current path.
- On each one-cycle sample trigger, issues NCH back-to-back single-channel ADC conversion requests (phase currents Ia, Ib, Ic by default) over a req/done handshake.
- Packs the results into one word and presents them to the Clarke transform with a one-cycle valid strobe.
- Guards each conversion with a timeout and flags triggers that arrive while a sequence is running.

---
 rtl/foc_adc_pkg.sv | 18 +
 rtl/adc_sample_sequencer.sv | 134 +++++++++++++
 tb/tb_adc_sample_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/foc_adc_pkg.sv
// Shared types and defaults for the FOC current-sampling ADC sequencer.
package foc_adc_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Default ADC result width in bits
    localparam int ADC_DW = 12;

    // Default number of phase currents converted per trigger (Ia, Ib, Ic)
    localparam int FOC_NPH = 3;

endpackage

// File: rtl/adc_sample_sequencer.sv
// ADC sample sequencer: on each trigger, converts channels 0..NCH-1 one at a time
// over a req/done handshake, packs the results and strobes them out. Every
// conversion is guarded by a timeout, and triggers that arrive mid-sequence are
// reported as overruns.
module adc_sample_sequencer
    import foc_adc_pkg::*;
#(
    parameter int          NCH     = FOC_NPH,
    parameter int          DW      = ADC_DW,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trig,
    output logic                adc_req,
    output logic [1:0]          adc_ch,
    input  logic                adc_done,
    input  logic [DW-1:0]       adc_data,
    output logic                o_en,
    output logic [NCH*DW-1:0]   o_data,
    output logic                o_err,
    output logic                busy,
    output logic                overrun
);

    localparam logic [1:0] LAST_CH = 2'(NCH - 1);

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [15:0]         timer_q, timer_d;
    logic [NCH*DW-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic                req_q, req_d;
    logic                en_q, en_d;
    logic                oerr_q, oerr_d;
    logic                busy_q, busy_d;
    logic                ovr_q, ovr_d;

    // Next-state logic: FSM, channel counter, timeout timer and result slots
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_REQ;
                    cnt_d   = 2'd0;
                    data_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_REQ: begin
                timer_d = TIMEOUT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the last timer cycle still counts as success
                if (adc_done) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (cnt_q == 2'(k)) begin
                            data_d[k*DW +: DW] = adc_data;
                        end
                    end
                    if (cnt_q == LAST_CH) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = ST_REQ;
                    end
                end else if (timer_q == 16'd0) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it
        req_d  = (state_d == ST_REQ);
        en_d   = (state_d == ST_DONE);
        oerr_d = (state_d == ST_DONE) && err_d;
        busy_d = (state_d != ST_IDLE);
        ovr_d  = trig && (state_q != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            timer_q <= 16'd0;
            data_q  <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            en_q    <= 1'b0;
            oerr_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            err_q   <= err_d;
            req_q   <= req_d;
            en_q    <= en_d;
            oerr_q  <= oerr_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    // The counter is cleared on acceptance and only moves on entry to REQ,
    // so it holds the channel steady from REQ through the end of WAIT
    assign adc_req = req_q;
    assign adc_ch  = cnt_q;
    assign o_en    = en_q;
    assign o_data  = data_q;
    assign o_err   = oerr_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench for adc_sample_sequencer (NCH=3, DW=12, TIMEOUT=4).
module tb_adc_sample_sequencer;

    localparam int          NCH = 3;
    localparam int          DW  = 12;
    localparam logic [15:0] TO  = 16'd4;
    localparam int          TOI = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              trig;
    logic              adc_req;
    logic [1:0]        adc_ch;
    logic              adc_done;
    logic [DW-1:0]     adc_data;
    logic              o_en;
    logic [NCH*DW-1:0] o_data;
    logic              o_err;
    logic              busy;
    logic              overrun;

    typedef struct {
        logic [NCH*DW-1:0] data;
        logic              err;
        int                cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            ch_q[$];
    int            ovr_q[$];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            resp_delay[NCH];
    logic [DW-1:0] resp_data[NCH];

    adc_sample_sequencer #(
        .NCH     (NCH),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trig     (trig),
        .adc_req  (adc_req),
        .adc_ch   (adc_ch),
        .adc_done (adc_done),
        .adc_data (adc_data),
        .o_en     (o_en),
        .o_data   (o_data),
        .o_err    (o_err),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
        end
    endtask

    // ADC model: answers each request after the per-channel delay (in WAIT cycles)
    initial begin
        int ch;
        int d;
        logic [DW-1:0] v;
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            if (adc_req && !rst) begin
                ch = int'(adc_ch);
                d  = resp_delay[ch];
                v  = resp_data[ch];
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1;
                adc_done = 1'b1;
                adc_data = v;
                @(posedge clk);
                #1;
                adc_done = 1'b0;
                adc_data = DW'($urandom);
            end
        end
    end

    // Monitor: compares every presented output against the scoreboard queues
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (adc_req) begin
                if (ch_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req at cycle %0d: adc_req=1, expected 0", cyc);
                end else begin
                    check("adc_ch", 64'(adc_ch), 64'(ch_q.pop_front()));
                    check("busy_at_req", 64'(busy), 64'd1);
                end
            end
            if (o_en) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_o_en at cycle %0d: o_en=1, expected 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("o_data", 64'(o_data), 64'(e.data));
                    check("o_err", 64'(o_err), 64'(e.err));
                    check("o_en_cycle", 64'(cyc), 64'(e.cyc));
                    check("busy_at_done", 64'(busy), 64'd1);
                end
            end
            if (overrun) begin
                if (ovr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_overrun at cycle %0d: overrun=1, expected 0", cyc);
                end else begin
                    check("overrun_cycle", 64'(cyc), 64'(ovr_q.pop_front()));
                end
            end
        end
    end

    // One sequence: model the outcome from the delays, then drive trig (and extra
    // trigs at offsets k1/k2; k1<0 picks a random in-sequence offset).
    // Entered and left just after a rising edge.
    task automatic run_seq(input int d0, input int d1, input int d2,
                           input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                           input logic [DW-1:0] x2, input int k1, input int k2, input bit b2b);
        int   dl[NCH];
        logic [DW-1:0] dt[NCH];
        exp_t e;
        int   len;
        int   t;
        int   span;
        int   ka;
        dl = '{d0, d1, d2};
        dt = '{x0, x1, x2};
        t  = cyc;
        e.data = '0;
        e.err  = 1'b0;
        len    = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            ch_q.push_back(ch);
            if (dl[ch] <= TOI) begin
                e.data[ch*DW +: DW] = dt[ch];
                len += 2 + dl[ch];
            end else begin
                e.err = 1'b1;
                len  += 2 + TOI;
                break;
            end
        end
        e.cyc = t + len + 1;
        span  = e.cyc - t;
        exp_q.push_back(e);
        ka = (k1 < 0) ? int'($urandom_range(span, 1)) : k1;
        if (ka > 0) ovr_q.push_back(t + ka + 1);
        if (k2 > 0) ovr_q.push_back(t + k2 + 1);
        for (int ch = 0; ch < NCH; ch++) begin
            resp_delay[ch] = dl[ch];
            resp_data[ch]  = dt[ch];
        end
        trig = 1'b1;
        for (int c = 1; c <= span; c++) begin
            @(posedge clk);
            #1;
            trig = (c == ka) || (c == k2);
        end
        @(posedge clk);
        #1;
        trig = 1'b0;
        if (!b2b) begin
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_adc_req"}, 64'(adc_req), 64'd0);
        check({tag, "_adc_ch"}, 64'(adc_ch), 64'd0);
        check({tag, "_o_en"}, 64'(o_en), 64'd0);
        check({tag, "_o_data"}, 64'(o_data), 64'd0);
        check({tag, "_o_err"}, 64'(o_err), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
    endtask

    initial begin
        rst  = 1'b1;
        trig = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            resp_delay[ch] = 0;
            resp_data[ch]  = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Nominal: done in first WAIT cycle
        run_seq(0, 0, 0, 12'h111, 12'h222, 12'h333, 0, 0, 1'b0);
        // Extra triggers mid-sequence and in the DONE cycle
        run_seq(0, 0, 0, 12'h4a5, 12'h5b6, 12'h6c7, 4, 7, 1'b0);
        // Timeout on ch0, then a trigger in the first IDLE cycle
        run_seq(5, 0, 0, 12'hfff, 12'heee, 12'hddd, 0, 0, 1'b1);
        run_seq(0, 1, 2, 12'h0a1, 12'h0b2, 12'h0c3, 0, 0, 1'b0);
        // Done coincides with timer==0: captured without error
        run_seq(4, 0, 0, 12'h9ab, 12'h123, 12'h456, 0, 0, 1'b0);
        // Late done on ch1 lands in DONE, back-to-back follow-up
        run_seq(0, 5, 0, 12'h777, 12'h888, 12'h999, 0, 0, 1'b1);
        run_seq(0, 0, 0, 12'h321, 12'h654, 12'h987, 0, 0, 1'b0);

        // Reset in the first WAIT cycle of ch1; the pending done goes stale
        ch_q.push_back(0);
        ch_q.push_back(1);
        resp_delay[0] = 0;
        resp_delay[1] = 2;
        resp_data[0]  = 12'habc;
        resp_data[1]  = 12'hdef;
        trig = 1'b1;
        @(posedge clk);
        #1;
        trig = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stale_done_busy", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1;

        // Randomized sequences
        for (int i = 0; i < 40; i++) begin
            run_seq(int'($urandom_range(6, 0)), int'($urandom_range(6, 0)),
                    int'($urandom_range(6, 0)), DW'($urandom), DW'($urandom), DW'($urandom),
                    ($urandom_range(2, 0) == 0) ? -1 : 0, 0, 1'($urandom_range(1, 0)));
        end

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pending_o_en", 64'(exp_q.size()), 64'd0);
        check("pending_req", 64'(ch_q.size()), 64'd0);
        check("pending_overrun", 64'(ovr_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
